data_mem_controller: RTL and testbench
======================================

# data_mem_controller

Load/store controller sitting between the RV32 core's memory stage and the word-addressed data RAM (64 × 32-bit, synchronous write, combinational read). It accepts byte-addressed RISC-V loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) over a req/ready/done handshake. It drives the RAM's writeEnable/address/writeData port and merges sub-word stores by read-modify-write. It also sign- or zero-extends load data and flags misaligned or out-of-range accesses.

## Interface
- MEM_WORDS, 64, number of 32-bit words in the attached RAM; valid word indices 0..MEM_WORDS-1
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  1  core requests an access; sampled only when ready=1
- isStore  input  1  1 = store, 0 = load
- funct3  input  3  RISC-V funct3: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW
- addr  input  32  byte address
- storeData  input  32  store source; low byte/halfword used for SB/SH
- ready  output  1  controller idle, request accepted this edge if req=1
- done  output  1  one-cycle pulse: access complete, loadData/error valid
- error  output  1  valid with done: misaligned, out-of-range or illegal funct3
- loadData  output  32  extended load result; held until next done
- writeEnable  output  1  RAM write strobe
- address  output  32  RAM word index (addr[31:2] of latched request)
- writeData  output  32  RAM write word
- readData  input  32  RAM combinational read data for `address`

## Operation
- Byte lanes little-endian: addr[1:0]=0 → bits 7:0, 1 → 15:8, 2 → 23:16, 3 → 31:24; halfword at addr[1]=0 → 15:0, 1 → 31:16.
- States: IDLE, READ, WRITE, DONE. ready = (state==IDLE).
- IDLE, req=1: latch isStore, funct3, addr, storeData. Then go to:
  - DONE with error set, if the access is faulty.
  - READ, for a load, SB or SH.
  - WRITE, for SW.
- An access is faulty if any of these holds:
  - Halfword with addr[0]=1.
  - Word with addr[1:0]≠0.
  - addr[31:2] ≥ MEM_WORDS.
  - Illegal funct3: loads 011/110/111, stores anything other than 000/001/010.
- Faulty accesses never touch the RAM.
- READ: address = latched word index, writeEnable=0.
  - Edge: capture readData into the word buffer.
  - Load → DONE; SB/SH → WRITE.
- WRITE: address = word index, writeEnable=1.
  - SW: writeData = storeData.
  - SB/SH: writeData = buffer with the selected lane(s) replaced by storeData[7:0]/[15:0]; other lanes unchanged.
  - Next state is DONE.
- DONE: done=1 for exactly this cycle. Next state is IDLE.
- loadData updates on entry to DONE:
  - LB/LH: sign-extend the selected lane.
  - LBU/LHU: zero-extend.
  - LW: full word.
  - Stores: loadData unchanged.
  - Error: loadData = 0.
- error is registered with done. It is 0 on every non-error completion.
- req while ready=0 is ignored; there is no queuing. Inputs may change freely after acceptance.
- writeEnable = (state==WRITE) && !reset, so no RAM write occurs on an edge where reset is asserted.
- address/writeData outside READ/WRITE: hold last value; writeEnable=0.

## Timing
- Reset (synchronous, checked at the edge) sets:
  - state = IDLE.
  - done = 0, error = 0, writeEnable = 0.
  - loadData = 0, address = 0, writeData = 0.
  - ready = 1 in the first cycle after reset.
- Reset mid-operation (READ/WRITE/DONE) aborts the access. No done pulse and no RAM write are produced.
- Latency, with the acceptance edge taken as cycle 0:
  - Load, SW, or faulty access: done in cycle 2, except faulty accesses, which assert done in cycle 1.
  - SB/SH: done in cycle 3.
- Cycle counts by access type:
  - Load: accept → READ (cycle 1) → DONE (cycle 2).
  - SW: accept → WRITE (cycle 1) → DONE (cycle 2).
  - SB/SH: accept → READ → WRITE → DONE (cycle 3).
  - Faulty: accept → DONE (cycle 1).
- ready returns the cycle after DONE. Back-to-back throughput is one access per 3 cycles (load/SW), 4 cycles (SB/SH) or 2 cycles (faulty).
- RAM timing: RAM writes at the rising edge ending the WRITE cycle. readData must settle combinationally within the READ cycle.

## Test plan
- SW then LW: store 0xDEADBEEF at addr 0x10 → RAM word 4 = 0xDEADBEEF; LW 0x10 → done in cycle 2, loadData 0xDEADBEEF, error 0.
- Byte merge:
  - Stimulus: word 4 = 0xDEADBEEF, then SB 0x12 at addr 0x11.
  - Required: word 4 = 0xDEAD12EF, done in cycle 3; LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE.
- Halfword:
  - Stimulus: SH 0x8001 at 0x12 (word 4 = 0xDEAD12EF).
  - Required: word = 0x800112EF; LH 0x12 → 0xFFFF8001; LHU 0x10 → 0x000012EF.
- Faults:
  - LW at 0x11, SH at 0x13, LW at 0x100 (index 64), funct3=011 load.
  - Each → done in cycle 1, error 1, loadData 0, writeEnable never asserted, RAM unchanged.
- Handshake:
  - req held high continuously with alternating accesses → each accepted only when ready=1.
  - req pulsed in READ is ignored; done is exactly one cycle wide.
- Reset:
  - Assert reset during the WRITE cycle of SB at 0x20 → RAM word 8 unchanged, no done.
  - After reset: ready=1, done=0, loadData=0; next LW completes normally.

Source files
------------

// File: rtl/data_mem_controller.sv
// Load/store controller between the RV32 memory stage and a word-addressed data RAM.
// Latency: faulty access done in cycle 1, load/SW in cycle 2, SB/SH (read-modify-write) in cycle 3.
// Backpressure: ready only in IDLE; req while busy is ignored (no queuing).
//
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   req, isStore, funct3, addr, storeData - request from core (sampled when ready=1)
//   ready, done, error, loadData          - handshake and completion status to core
//   writeEnable, address, writeData, readData - RAM port (combinational read)
module data_mem_controller #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        isStore,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] storeData,
    output logic        ready,
    output logic        done,
    output logic        error,
    output logic [31:0] loadData,
    output logic        writeEnable,
    output logic [31:0] address,
    output logic [31:0] writeData,
    input  logic [31:0] readData
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t state;

    // Latched request fields needed after acceptance. Only the low halfword of
    // the store data is kept: full-word stores load writeData at acceptance.
    logic        st_store;
    logic [2:0]  st_f3;
    logic [1:0]  st_lane;
    logic [15:0] st_data;

    logic        f3_bad, misalign, out_of_range, faulty;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // Fault classification on the live request inputs.
    always_comb begin
        f3_bad       = isStore ? (funct3 > 3'b010)
                               : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
        misalign     = (funct3[1:0] == 2'b01 && addr[0]) ||
                       (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
        out_of_range = ({2'b00, addr[31:2]} >= 32'(MEM_WORDS));
        faulty       = f3_bad || misalign || out_of_range;
    end

    // Lane selection and extension of the RAM word for loads.
    always_comb begin
        ld_byte = readData[{st_lane, 3'b000} +: 8];
        ld_half = st_lane[1] ? readData[31:16] : readData[15:0];
        case (st_f3)
            3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_ext = {24'h0, ld_byte};
            3'b101:  load_ext = {16'h0, ld_half};
            default: load_ext = readData;
        endcase
    end

    // Sub-word store merge: replace only the addressed lane(s).
    always_comb begin
        merged = readData;
        if (st_f3[1:0] == 2'b00)
            merged[{st_lane, 3'b000} +: 8] = st_data[7:0];
        else if (st_lane[1])
            merged[31:16] = st_data;
        else
            merged[15:0] = st_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            done      <= 1'b0;
            error     <= 1'b0;
            loadData  <= 32'h0;
            address   <= 32'h0;
            writeData <= 32'h0;
            st_store  <= 1'b0;
            st_f3     <= 3'b000;
            st_lane   <= 2'b00;
            st_data   <= 16'h0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        st_store <= isStore;
                        st_f3    <= funct3;
                        st_lane  <= addr[1:0];
                        st_data  <= storeData[15:0];
                        if (faulty) begin
                            // Faulty accesses skip the RAM entirely.
                            state    <= DONE;
                            done     <= 1'b1;
                            error    <= 1'b1;
                            loadData <= 32'h0;
                        end else begin
                            address <= {2'b00, addr[31:2]};
                            if (isStore && funct3[1:0] == 2'b10) begin
                                writeData <= storeData;
                                state     <= WRITE;
                            end else begin
                                state <= READ;
                            end
                        end
                    end
                end
                READ: begin
                    if (st_store) begin
                        writeData <= merged;
                        state     <= WRITE;
                    end else begin
                        loadData <= load_ext;
                        error    <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                WRITE: begin
                    error <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ready       = (state == IDLE);
    // Gated by reset so an aborting reset edge never commits a RAM write.
    assign writeEnable = (state == WRITE) && !reset;

endmodule

// File: tb/tb_data_mem_controller.sv
module tb_data_mem_controller;
    localparam int MW = 64;

    logic        clk = 1'b0;
    logic        reset, req, isStore;
    logic [2:0]  funct3;
    logic [31:0] addr, storeData, loadData, address, writeData, readData;
    logic        ready, done, error, writeEnable;

    int tests = 0;
    int failed = 0;
    int we_count = 0;

    always #5 clk = ~clk;

    data_mem_controller #(.MEM_WORDS(MW)) dut (
        .clk(clk), .reset(reset), .req(req), .isStore(isStore), .funct3(funct3),
        .addr(addr), .storeData(storeData), .ready(ready), .done(done), .error(error),
        .loadData(loadData), .writeEnable(writeEnable), .address(address),
        .writeData(writeData), .readData(readData)
    );

    // Attached RAM: synchronous write, combinational read.
    logic [31:0] ram [MW];
    assign readData = (address < MW) ? ram[address[5:0]] : 32'h0;
    always @(posedge clk) begin
        if (writeEnable) begin
            we_count <= we_count + 1;
            if (address < MW) ram[address[5:0]] <= writeData;
        end
    end

    // Reference model: byte-addressed memory plus the last reported load value.
    logic [7:0]  mem_m [4*MW];
    logic [31:0] last_ld;

    task automatic model_apply(input bit st, input bit [2:0] f3, input logic [31:0] a,
                               input logic [31:0] d, output int lat, output bit err,
                               output logic [31:0] ld);
        int n;
        bit bad_f3;
        logic [31:0] v;
        bad_f3 = st ? (f3 > 2) : (f3 == 3 || f3 >= 6);
        n = 1 << f3[1:0];
        err = bad_f3 || (a % n != 0) || (a / 4 >= MW);
        if (err) begin
            lat = 1;
            last_ld = 32'h0;
        end else if (st) begin
            for (int i = 0; i < n; i++) mem_m[a + i] = d[8*i +: 8];
            lat = (n == 4) ? 2 : 3;
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(mem_m[a + i]) << (8 * i));
            if (n < 4 && !f3[2] && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            last_ld = v;
            lat = 2;
        end
        ld = last_ld;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Issue one access from IDLE (called #1 after a rising edge). lat is the
    // cycle number of done with the acceptance edge as cycle 0; 0 means timeout.
    task automatic do_access(input bit st, input bit [2:0] f3, input logic [31:0] a,
                             input logic [31:0] d, output int lat, output bit err,
                             output logic [31:0] ld);
        bit seen;
        isStore = st; funct3 = f3; addr = a; storeData = d; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; isStore = 1'b0; funct3 = 3'b111; addr = 32'hFFFF_FFFF; storeData = 32'h0;
        lat = 0; err = 1'b0; ld = 32'hX; seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (done) begin
                lat = c + 1; err = error; ld = loadData; seen = 1'b1;
            end
        end
        @(posedge clk); #1;
        check("done_one_cycle", {31'h0, done}, 32'h0);
    endtask

    typedef struct {
        bit          st;
        bit [2:0]    f3;
        logic [31:0] a;
        logic [31:0] d;
        int          lat;
        bit          err;
        logic [31:0] ld;
    } vec_t;

    vec_t        tbl [15];
    int          lat, mlat, we0, dcnt;
    bit          err, merr, dbl, prev_done;
    logic [31:0] ld, mld, word8;
    logic [31:0] hq [$];
    int          bad_words;

    initial begin
        tbl[0]  = '{1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 0, 32'h0};
        tbl[1]  = '{0, 3'b010, 32'h10, 32'h0,        2, 0, 32'hDEADBEEF};
        tbl[2]  = '{1, 3'b000, 32'h11, 32'h12,       3, 0, 32'hDEADBEEF};
        tbl[3]  = '{0, 3'b010, 32'h10, 32'h0,        2, 0, 32'hDEAD12EF};
        tbl[4]  = '{0, 3'b000, 32'h13, 32'h0,        2, 0, 32'hFFFFFFDE};
        tbl[5]  = '{0, 3'b100, 32'h13, 32'h0,        2, 0, 32'h000000DE};
        tbl[6]  = '{1, 3'b001, 32'h12, 32'h8001,     3, 0, 32'h000000DE};
        tbl[7]  = '{0, 3'b010, 32'h10, 32'h0,        2, 0, 32'h800112EF};
        tbl[8]  = '{0, 3'b001, 32'h12, 32'h0,        2, 0, 32'hFFFF8001};
        tbl[9]  = '{0, 3'b101, 32'h10, 32'h0,        2, 0, 32'h000012EF};
        tbl[10] = '{0, 3'b010, 32'h11, 32'h0,        1, 1, 32'h0};
        tbl[11] = '{1, 3'b001, 32'h13, 32'h5555,     1, 1, 32'h0};
        tbl[12] = '{0, 3'b010, 32'h100, 32'h0,       1, 1, 32'h0};
        tbl[13] = '{0, 3'b011, 32'h0,  32'h0,        1, 1, 32'h0};
        tbl[14] = '{0, 3'b010, 32'h10, 32'h0,        2, 0, 32'h800112EF};

        for (int i = 0; i < MW; i++) ram[i] = 32'h0;
        for (int i = 0; i < 4*MW; i++) mem_m[i] = 8'h0;
        last_ld = 32'h0;
        reset = 1'b1; req = 1'b0; isStore = 1'b0; funct3 = 3'b0; addr = 32'h0; storeData = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state.
        check("rst_ready", {31'h0, ready}, 32'h1);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_error", {31'h0, error}, 32'h0);
        check("rst_we", {31'h0, writeEnable}, 32'h0);
        check("rst_loadData", loadData, 32'h0);
        check("rst_address", address, 32'h0);
        check("rst_writeData", writeData, 32'h0);

        // Directed table.
        foreach (tbl[i]) begin
            we0 = we_count;
            do_access(tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].d, lat, err, ld);
            model_apply(tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].d, mlat, merr, mld);
            check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
            check($sformatf("tbl%0d_error", i), {31'h0, err}, {31'h0, tbl[i].err});
            check($sformatf("tbl%0d_loadData", i), ld, tbl[i].ld);
            if (tbl[i].err) check($sformatf("tbl%0d_no_write", i), 32'(we_count), 32'(we0));
        end
        check("word4_after_table", ram[4], 32'h800112EF);

        // req held high continuously, alternating load addresses.
        dcnt = 0; dbl = 1'b0; prev_done = 1'b0;
        isStore = 1'b0; funct3 = 3'b010; addr = 32'h10; req = 1'b1;
        hq.push_back(32'h10);
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
            if (done && prev_done) dbl = 1'b1;
            prev_done = done;
            if (done) begin
                dcnt++;
                model_apply(0, 3'b010, hq.pop_front(), 32'h0, mlat, merr, mld);
                check("held_req_loadData", loadData, mld);
                check("held_req_ready_low", {31'h0, ready}, 32'h0);
            end
            if (ready) begin
                addr = (addr == 32'h10) ? 32'h14 : 32'h10;
                hq.push_back(addr);
            end
        end
        req = 1'b0;
        check("held_req_done_count", 32'(dcnt), 32'd4);
        check("held_req_done_width", {31'h0, dbl}, 32'h0);
        @(posedge clk); #1;

        // req pulsed during READ is ignored.
        we0 = we_count; dcnt = 0;
        isStore = 1'b0; funct3 = 3'b010; addr = 32'h14; req = 1'b1;
        @(posedge clk); #1;
        isStore = 1'b1; addr = 32'h18; storeData = 32'hCAFEF00D;
        @(posedge clk); #1;
        req = 1'b0;
        if (done) dcnt++;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        model_apply(0, 3'b010, 32'h14, 32'h0, mlat, merr, mld);
        check("busy_req_done_count", 32'(dcnt), 32'd1);
        check("busy_req_no_write", 32'(we_count), 32'(we0));
        check("busy_req_loadData", loadData, mld);

        // Reset during the WRITE cycle of SB at 0x20 aborts it.
        word8 = {mem_m[35], mem_m[34], mem_m[33], mem_m[32]};
        dcnt = 0;
        isStore = 1'b1; funct3 = 3'b000; addr = 32'h20; storeData = 32'hAB; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        if (done) dcnt++;
        @(posedge clk); #1;
        if (done) dcnt++;
        check("rst_abort_in_write", {31'h0, writeEnable}, 32'h1);
        reset = 1'b1;
        #1 check("rst_abort_we_gated", {31'h0, writeEnable}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        if (done) dcnt++;
        last_ld = 32'h0;
        check("rst_abort_no_done", 32'(dcnt), 32'd0);
        check("rst_abort_word8", ram[8], word8);
        check("rst_abort_ready", {31'h0, ready}, 32'h1);
        check("rst_abort_loadData", loadData, 32'h0);
        do_access(0, 3'b010, 32'h20, 32'h0, lat, err, ld);
        model_apply(0, 3'b010, 32'h20, 32'h0, mlat, merr, mld);
        check("post_rst_latency", 32'(lat), 32'(mlat));
        check("post_rst_loadData", ld, mld);

        // Randomized accesses against the model.
        for (int i = 0; i < 150; i++) begin
            bit          st;
            bit [2:0]    f3;
            logic [31:0] a, d;
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 4*MW + 7));
            d  = $urandom;
            we0 = we_count;
            do_access(st, f3, a, d, lat, err, ld);
            model_apply(st, f3, a, d, mlat, merr, mld);
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(mlat));
            check($sformatf("rnd%0d_error", i), {31'h0, err}, {31'h0, merr});
            check($sformatf("rnd%0d_loadData", i), ld, mld);
            if (merr) check($sformatf("rnd%0d_no_write", i), 32'(we_count), 32'(we0));
        end

        bad_words = 0;
        for (int w = 0; w < MW; w++)
            if (ram[w] !== {mem_m[4*w+3], mem_m[4*w+2], mem_m[4*w+1], mem_m[4*w]}) bad_words++;
        check("final_ram_contents_bad_words", 32'(bad_words), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
